// File: rtl/md5_search_pkg.sv
// Shared types and constants for the MD5 brute-force search controller.
// Holds the controller state encoding, digest width and ASCII digit bounds.
package md5_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_FOUND     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } state_e;

  localparam int         HASH_W  = 128;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

endpackage

// File: rtl/ascii_dec_ctr.sv
// ASCII-decimal candidate counter: last character increments first, '9' carries.
// The wrapped flag latches when the all-'9' value is consumed by an increment.
module ascii_dec_ctr
  import md5_search_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                inc,
  output logic [8*DIGITS-1:0] value,
  output logic                wrapped
);

  logic [8*DIGITS-1:0] value_q, value_d, value_inc;
  logic                wrapped_q, wrapped_d;
  logic                carry;

  // Ripple from the rightmost character; carry out means the value was all '9'.
  always_comb begin
    value_inc = value_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[i*8 +: 8] == ASCII_9) begin
          value_inc[i*8 +: 8] = ASCII_0;
        end else begin
          value_inc[i*8 +: 8] = value_q[i*8 +: 8] + 8'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // NOTE: each _d is given its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    value_d   = value_q;
    wrapped_d = wrapped_q;
    if (clear) begin
      value_d   = {DIGITS{ASCII_0}};
      wrapped_d = 1'b0;
    end else if (inc) begin
      value_d = value_inc;
      if (carry) wrapped_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q   <= {DIGITS{ASCII_0}};
      wrapped_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign value   = value_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/md5_search_ctrl.sv
// Dispatches ASCII-decimal candidates to a pool of MD5 cores and watches their
// digests for a match against a latched target, timing the search in milliseconds.
module md5_search_ctrl
  import md5_search_pkg::*;
#(
  parameter int NUM_CORES  = 10,
  parameter int DIGITS     = 8,
  parameter int CLK_PER_MS = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [HASH_W-1:0]             target_hash,
  output logic [NUM_CORES-1:0]          core_req,
  output logic [NUM_CORES*8*DIGITS-1:0] core_txt,
  input  logic [NUM_CORES-1:0]          core_valid,
  input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
  output logic                          busy,
  output logic                          found,
  output logic                          exhausted,
  output logic [8*DIGITS-1:0]           ans_txt,
  output logic [31:0]                   elapsed_ms
);

  localparam int                 TXT_W     = 8*DIGITS;
  localparam int                 PRESC_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);

  state_e                        state_q, state_d;
  logic [NUM_CORES-1:0]          core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]          core_req_q, core_req_d;
  logic [NUM_CORES*TXT_W-1:0]    core_txt_q, core_txt_d;
  logic [HASH_W-1:0]             target_q, target_d;
  logic                          found_q, found_d;
  logic                          exhausted_q, exhausted_d;
  logic [TXT_W-1:0]              ans_q, ans_d;
  logic [31:0]                   elapsed_q, elapsed_d;
  logic [PRESC_W-1:0]            presc_q, presc_d;

  logic                          cnt_clear, cnt_inc, cnt_wrapped;
  logic [TXT_W-1:0]              cnt_value;
  logic [NUM_CORES-1:0]          disp_oh;
  logic                          match;
  logic [TXT_W-1:0]              match_txt;

  ascii_dec_ctr #(.DIGITS(DIGITS)) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .value   (cnt_value),
    .wrapped (cnt_wrapped)
  );

  // Lowest idle core: isolate the lowest zero bit of the busy mask.
  assign disp_oh = ~core_busy_q & (core_busy_q + NUM_CORES'(1));

  // Scan high to low so the lowest-index matching core is the one kept.
  always_comb begin
    match     = 1'b0;
    match_txt = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_valid[i] && core_busy_q[i] &&
          (core_hash[i*HASH_W +: HASH_W] == target_q)) begin
        match     = 1'b1;
        match_txt = core_txt_q[i*TXT_W +: TXT_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    core_busy_d = core_busy_q;
    core_req_d  = '0;
    core_txt_d  = core_txt_q;
    target_d    = target_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    ans_d       = ans_q;
    elapsed_d   = elapsed_q;
    presc_d     = presc_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;

    if (state_q == ST_RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (elapsed_q != '1) elapsed_d = elapsed_q + 32'd1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end

      core_busy_d = core_busy_q & ~core_valid;

      // Dispatch is suppressed on every exit so core_req never lands outside RUN.
      if (abort) begin
        state_d = ST_IDLE;
      end else if (match) begin
        found_d = 1'b1;
        ans_d   = match_txt;
        state_d = ST_FOUND;
      end else if (cnt_wrapped && (core_busy_d == '0)) begin
        exhausted_d = 1'b1;
        state_d     = ST_EXHAUSTED;
      end else if (!cnt_wrapped && (disp_oh != '0)) begin
        cnt_inc     = 1'b1;
        core_req_d  = disp_oh;
        core_busy_d = core_busy_d | disp_oh;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (disp_oh[i]) core_txt_d[i*TXT_W +: TXT_W] = cnt_value;
        end
      end
    end else if (start) begin
      state_d     = ST_RUN;
      cnt_clear   = 1'b1;
      core_busy_d = '0;
      target_d    = target_hash;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      ans_d       = '0;
      elapsed_d   = '0;
      presc_d     = '0;
    end
  end

  // NOTE: wide datapath registers (core_txt, ans_txt) are reset too, since reset must drive them visibly to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      core_busy_q <= '0;
      core_req_q  <= '0;
      core_txt_q  <= '0;
      target_q    <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      ans_q       <= '0;
      elapsed_q   <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      core_busy_q <= core_busy_d;
      core_req_q  <= core_req_d;
      core_txt_q  <= core_txt_d;
      target_q    <= target_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      ans_q       <= ans_d;
      elapsed_q   <= elapsed_d;
      presc_q     <= presc_d;
    end
  end

  assign core_req   = core_req_q;
  assign core_txt   = core_txt_q;
  assign busy       = (state_q == ST_RUN);
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign ans_txt    = ans_q;
  assign elapsed_ms = elapsed_q;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Directed bench for md5_search_ctrl with 3 cores, 2 digits and a 10-cycle millisecond.
// A behavioural core model answers each request after a per-core latency.
module tb_md5_search_ctrl;

  localparam int NC = 3;
  localparam int TW = 16;

  logic             clk         = 1'b0;
  logic             reset_n     = 1'b0;
  logic             start       = 1'b0;
  logic             abort       = 1'b0;
  logic [127:0]     target_hash = '0;
  logic [NC-1:0]    core_req;
  logic [NC*TW-1:0] core_txt;
  logic [NC-1:0]    core_valid  = '0;
  logic [NC*128-1:0] core_hash  = '0;
  logic             busy, found, exhausted;
  logic [TW-1:0]    ans_txt;
  logic [31:0]      elapsed_ms;

  int tests_run    = 0;
  int tests_failed = 0;

  int            pend [NC]      = '{default: 0};
  int            lat  [NC]      = '{4, 4, 4};
  logic [TW-1:0] cap_txt [NC];
  int            req_count      = 0;
  int            bad_req        = 0;
  int            seen [100]     = '{default: 0};
  int            seen_snap [100];
  bit            force_match    = 1'b0;

  md5_search_ctrl #(
    .NUM_CORES  (NC),
    .DIGITS     (2),
    .CLK_PER_MS (10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .target_hash (target_hash),
    .core_req    (core_req),
    .core_txt    (core_txt),
    .core_valid  (core_valid),
    .core_hash   (core_hash),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .ans_txt     (ans_txt),
    .elapsed_ms  (elapsed_ms)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_hash(input logic [TW-1:0] txt);
    return {16'hC0FE, 96'h0123_4567_89AB_CDEF_0011_2233, txt};
  endfunction

  // Core model and request monitor, both working on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      core_valid[i] = 1'b0;
      if (pend[i] > 0) begin
        pend[i] = pend[i] - 1;
        if (pend[i] == 0) begin
          core_valid[i] = 1'b1;
          core_hash[i*128 +: 128] = force_match ? target_hash : model_hash(cap_txt[i]);
        end
      end
      if (core_req[i]) begin
        int idx;
        pend[i]    = lat[i];
        cap_txt[i] = core_txt[i*TW +: TW];
        req_count++;
        if (!busy) bad_req++;
        idx = (int'(cap_txt[i][15:8]) - 48) * 10 + (int'(cap_txt[i][7:0]) - 48);
        if (idx >= 0 && idx < 100) seen[idx]++;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output logic done);
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (found || exhausted) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic done;
    int   req_snap;
    int   n_bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_ans_txt", ans_txt, 0);
    check("rst_elapsed", elapsed_ms, 0);
    check("rst_core_req", core_req, 0);
    check("rst_core_txt", core_txt, 0);
    reset_n = 1'b1;

    // Search for "42"
    target_hash = model_hash(16'h3432);
    pulse_start();
    check("a_busy", busy, 1);
    wait_done(500, done);
    check("a_done", done, 1);
    check("a_found", found, 1);
    check("a_exhausted", exhausted, 0);
    check("a_ans_txt", ans_txt, 16'h3432);
    check("a_busy_after", busy, 0);
    req_snap = req_count;
    repeat (20) @(negedge clk);
    check("a_no_req_after_found", req_count, req_snap);
    check("a_found_held", found, 1);

    // Unmatchable target covers the whole space
    target_hash = '0;
    seen_snap   = seen;
    req_snap    = req_count;
    pulse_start();
    check("b_cleared_found", found, 0);
    check("b_cleared_ans", ans_txt, 0);
    wait_done(2000, done);
    check("b_done", done, 1);
    check("b_exhausted", exhausted, 1);
    check("b_found", found, 0);
    check("b_busy", busy, 0);
    check("b_req_total", req_count - req_snap, 100);
    n_bad = 0;
    for (int k = 0; k < 100; k++) if (seen[k] - seen_snap[k] != 1) n_bad++;
    check("b_each_candidate_once", n_bad, 0);
    repeat (10) @(negedge clk);

    // Cores 0 and 1 return matching results in the same cycle
    force_match = 1'b1;
    lat         = '{5, 4, 4};
    target_hash = 128'h1234;
    pulse_start();
    wait_done(100, done);
    check("c_done", done, 1);
    check("c_found", found, 1);
    check("c_exhausted", exhausted, 0);
    check("c_ans_lowest_core", ans_txt, 16'h3030);
    repeat (15) @(negedge clk);
    force_match = 1'b0;
    lat         = '{4, 4, 4};

    // Abort after 35 RUN cycles
    target_hash = '0;
    pulse_start();
    repeat (34) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("d_busy_after_abort", busy, 0);
    check("d_elapsed", elapsed_ms, 3);
    check("d_found", found, 0);
    check("d_exhausted", exhausted, 0);
    req_snap = req_count;
    repeat (20) @(negedge clk);
    check("d_no_req_after_abort", req_count, req_snap);
    check("d_elapsed_frozen", elapsed_ms, 3);

    // Restart clears the timer; a start during RUN is ignored
    seen_snap = seen;
    req_snap  = req_count;
    pulse_start();
    check("e_elapsed_cleared", elapsed_ms, 0);
    check("e_busy", busy, 1);
    repeat (14) @(negedge clk);
    check("e_elapsed_14cyc", elapsed_ms, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("e_busy_after_restart_pulse", busy, 1);
    check("e_elapsed_15cyc", elapsed_ms, 1);
    repeat (5) @(negedge clk);
    check("e_elapsed_20cyc", elapsed_ms, 2);
    wait_done(2000, done);
    check("e_done", done, 1);
    check("e_exhausted", exhausted, 1);
    check("e_req_total", req_count - req_snap, 100);
    n_bad = 0;
    for (int k = 0; k < 100; k++) if (seen[k] - seen_snap[k] != 1) n_bad++;
    check("e_each_candidate_once", n_bad, 0);
    repeat (10) @(negedge clk);

    // Reset mid-RUN with cores busy; the "01" result arrives after release
    target_hash = model_hash(16'h3031);
    pulse_start();
    repeat (4) @(negedge clk);
    check("f_busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    check("f_rst_busy", busy, 0);
    check("f_rst_core_req", core_req, 0);
    check("f_rst_core_txt", core_txt, 0);
    check("f_rst_found", found, 0);
    check("f_rst_exhausted", exhausted, 0);
    check("f_rst_ans_txt", ans_txt, 0);
    check("f_rst_elapsed", elapsed_ms, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("f_late_found", found, 0);
    check("f_late_busy", busy, 0);
    check("f_late_ans_txt", ans_txt, 0);
    check("f_late_exhausted", exhausted, 0);
    check("f_no_req_outside_run", bad_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/md5_search_ctrl.md
MD5_SEARCH_CTRL -- requirements
Module: md5_search_ctrl

Interface
REQ-001 SHALL provide parameter NUM_CORES, default 10: number of attached hash cores, 1..16.
REQ-002 SHALL provide parameter DIGITS, default 8: candidate length in ASCII decimal digits, 1..10.
REQ-003 SHALL provide parameter CLK_PER_MS, default 100000: clk cycles per millisecond tick.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse; begins a search.
REQ-007 abort  input  1  single-cycle pulse; cancels a running search.
REQ-008 target_hash  input  128  digest to match, bit 127 = first digest byte MSB; sampled on accepted start.
REQ-009 core_req  output  NUM_CORES  per-core one-cycle request pulse.
REQ-010 core_txt  output  NUM_CORES*8*DIGITS  per-core candidate; slice i = core i; most significant byte = first character.
REQ-011 core_valid  input  NUM_CORES  per-core one-cycle result pulse.
REQ-012 core_hash  input  NUM_CORES*128  per-core digest, meaningful only while matching core_valid bit is 1.
REQ-013 busy  output  1  search in progress.
REQ-014 found  output  1  match found; held until next start or reset.
REQ-015 exhausted  output  1  full space searched without match; held until next start or reset.
REQ-016 ans_txt  output  8*DIGITS  matching candidate.
REQ-017 elapsed_ms  output  32  binary milliseconds since accepted start.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FOUND, EXHAUSTED; busy = 1 only in RUN.
REQ-019 start in IDLE, FOUND or EXHAUSTED SHALL go to RUN next cycle: candidate counter = all ASCII "0", found/exhausted/ans_txt/elapsed_ms/prescaler cleared, target_hash latched, all cores marked idle.
REQ-020 start while in RUN SHALL be ignored.
REQ-021 abort in RUN SHALL go to IDLE next cycle, keeping elapsed_ms; abort outside RUN ignored; abort and start in the same cycle: abort wins in RUN.
REQ-022 Candidate counter SHALL be ASCII-decimal, DIGITS wide, incrementing last character first with carry at '9' -> '0'; a "space wrapped" flag SHALL set when all-'9' is dispatched.
REQ-023 In RUN, at most one dispatch per cycle to the lowest-index idle core, only while space not wrapped: core_txt slice loaded, core_req pulsed one cycle, core marked busy, counter advances.
REQ-024 core_txt slice SHALL stay stable from core_req until that core's core_valid; core_valid marks core idle the same cycle (re-dispatch no earlier than next cycle).
REQ-025 core_valid with core_hash == latched target in RUN SHALL set found, load ans_txt from that core's slice, go to FOUND next cycle; several simultaneous matches: lowest index wins.
REQ-026 core_valid for an idle core, or arriving outside RUN, SHALL be ignored.
REQ-027 Space wrapped and all cores idle and no match this cycle SHALL set exhausted and go to EXHAUSTED; match in the final-result cycle SHALL give FOUND, never both flags.
REQ-028 No core_req SHALL be issued outside RUN.
REQ-029 Prescaler SHALL count clk cycles in RUN only; at CLK_PER_MS-1 it SHALL wrap to 0 and increment elapsed_ms, saturating at 32'hFFFFFFFF; elapsed_ms frozen outside RUN.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, counter all "0", core_req/core_txt/busy/found/exhausted/ans_txt/elapsed_ms/prescaler = 0, all cores idle, wrapped flag = 0.
REQ-031 Reset mid-RUN SHALL discard in-flight core results; results after release ignored (cores idle, state IDLE).

Structure
REQ-032 Shared package md5_search_pkg SHALL hold the FSM state enum, HASH_W = 128 and ASCII constants '0'/'9'.
REQ-033 The ASCII-decimal counter with wrap flag SHALL be sub-module ascii_dec_ctr (parameter DIGITS; ports clk, reset_n, clear, inc, value, wrapped).

Verification
REQ-034 DIGITS=2, NUM_CORES=3, core model latency 4, target = model hash of "42" -> found=1, ans_txt="42", exhausted=0, no core_req after FOUND.
REQ-035 Same config, target matching no candidate -> exactly 100 core_req pulses total, candidates "00".."99" once each, then exhausted=1, busy=0.
REQ-036 Two cores pulse core_valid in the same cycle, both matching (model forced) -> ans_txt equals lower-index core's txt.
REQ-037 CLK_PER_MS=10, abort after 35 RUN cycles -> state IDLE, elapsed_ms=3, no further core_req; next start clears elapsed_ms to 0.
REQ-038 reset_n low 2 cycles mid-RUN with cores busy -> all outputs 0 immediately; late core_valid pulses after release leave found=0.
REQ-039 start pulse during RUN -> ignored, counter and elapsed_ms continue undisturbed.
